// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample-size codes, word-select levels and the
// code-to-bit-count decode used by both the transmitter and the receiver.
package i2s_pkg;

    localparam logic [3:0] S_8BIT  = 4'd0;
    localparam logic [3:0] S_12BIT = 4'd1;
    localparam logic [3:0] S_16BIT = 4'd3;
    localparam logic [3:0] S_32BIT = 4'd4;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Reserved codes fall back to 16-bit words.
    function automatic logic [5:0] size_to_bits(input logic [3:0] code);
        logic [5:0] bits;
        case (code)
            S_8BIT:  bits = 6'd8;
            S_12BIT: bits = 6'd12;
            S_16BIT: bits = 6'd16;
            S_32BIT: bits = 6'd32;
            default: bits = 6'd16;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall detection. The level
// output is delayed one extra flop so it lines up with the edge strobes:
// data sampled through this block is coherent with a strobe from a sibling.
module i2s_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Synchroniser chain, history flop and edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S (Philips) capture: synchronises SCK/WS/SD into clk, deserialises
// left/right words MSB-first with the one-bit WS delay, and presents
// sign-extended stereo pairs on a valid/ready interface.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned MAX_BITS    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [3:0]          sample_size,
    input  logic                sck_in,
    input  logic                ws_in,
    input  logic                sd_in,
    output logic [MAX_BITS-1:0] sample_left,
    output logic [MAX_BITS-1:0] sample_right,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    output logic                frame_error
);

    typedef enum logic [1:0] {StIdle, StSync, StLeft, StRight} state_e;

    state_e              state_q, state_d;
    logic                bit_tick, ws_s, sd_s;
    logic                ws_prev_q, ws_prev_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic [MAX_BITS-1:0] stage_q, stage_d;
    logic [MAX_BITS-1:0] left_q, left_d;
    logic [MAX_BITS-1:0] right_q, right_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [5:0]          len_q, len_d;
    logic                left_ok_q, left_ok_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                ferr_q, ferr_d;

    logic                ws_change, capture, emit, load;
    logic [MAX_BITS-1:0] shift_nxt;
    logic [5:0]          cnt_nxt;

    logic unused_sck_level, unused_sck_fall;
    logic unused_ws_rise, unused_ws_fall, unused_sd_rise, unused_sd_fall;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk   (clk),
        .rst   (rst),
        .din   (sck_in),
        .level (unused_sck_level),
        .rise  (bit_tick),
        .fall  (unused_sck_fall)
    );

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .clk   (clk),
        .rst   (rst),
        .din   (ws_in),
        .level (ws_s),
        .rise  (unused_ws_rise),
        .fall  (unused_ws_fall)
    );

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk   (clk),
        .rst   (rst),
        .din   (sd_in),
        .level (sd_s),
        .rise  (unused_sd_rise),
        .fall  (unused_sd_fall)
    );

    // Replicate bit n-1 into every bit at or above n.
    function automatic logic [MAX_BITS-1:0] sign_extend(input logic [MAX_BITS-1:0] v,
                                                        input logic [5:0]          n);
        logic [MAX_BITS-1:0] hi_mask;
        logic [MAX_BITS-1:0] top_mask;
        hi_mask  = {MAX_BITS{1'b1}} << n;
        top_mask = {{(MAX_BITS-1){1'b0}}, 1'b1} << (n - 6'd1);
        return (|(v & top_mask)) ? (v | hi_mask) : v;
    endfunction

    // Next-state: word framing, capture, pair emission and pulse outputs.
    always_comb begin
        state_d   = state_q;
        ws_prev_d = ws_prev_q;
        shift_d   = shift_q;
        stage_d   = stage_q;
        left_d    = left_q;
        right_d   = right_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        left_ok_d = left_ok_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        ferr_d    = 1'b0;
        emit      = 1'b0;
        load      = 1'b0;

        ws_change = ws_s != ws_prev_q;
        // Bits beyond N are padding and leave the shifter alone.
        capture   = cnt_q < len_q;
        shift_nxt = capture ? {shift_q[MAX_BITS-2:0], sd_s} : shift_q;
        cnt_nxt   = capture ? cnt_q + 6'd1 : cnt_q;

        if (bit_tick) begin
            ws_prev_d = ws_s;
        end

        // On a WS-change tick, SD still belongs to the old word (one-bit delay).
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StSync;
                    len_d   = size_to_bits(sample_size);
                end
            end
            StSync: begin
                if (bit_tick && ws_change && ws_s == WS_LEFT) begin
                    state_d = StLeft;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            StLeft: begin
                if (bit_tick) begin
                    if (ws_change && ws_s == WS_RIGHT) begin
                        if (cnt_nxt == len_q) begin
                            stage_d   = shift_nxt;
                            left_ok_d = 1'b1;
                        end else begin
                            ferr_d    = 1'b1;
                            left_ok_d = 1'b0;
                        end
                        state_d = StRight;
                        shift_d = '0;
                        cnt_d   = '0;
                    end else begin
                        shift_d = shift_nxt;
                        cnt_d   = cnt_nxt;
                    end
                end
            end
            StRight: begin
                if (bit_tick) begin
                    if (capture && cnt_nxt == len_q && left_ok_q) begin
                        emit = 1'b1;
                    end
                    if (ws_change && ws_s == WS_LEFT) begin
                        if (cnt_nxt != len_q) begin
                            ferr_d = 1'b1;
                        end
                        state_d   = StLeft;
                        shift_d   = '0;
                        cnt_d     = '0;
                        left_ok_d = 1'b0;
                    end else begin
                        shift_d = shift_nxt;
                        cnt_d   = cnt_nxt;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Disable drops any partial word but leaves the output side alone.
        if (!enable) begin
            state_d   = StIdle;
            shift_d   = '0;
            cnt_d     = '0;
            left_ok_d = 1'b0;
            ferr_d    = 1'b0;
            emit      = 1'b0;
        end

        load = emit && (!valid_q || sample_ready);
        if (load) begin
            left_d  = sign_extend(stage_q, len_q);
            right_d = sign_extend(shift_nxt, len_q);
            valid_d = 1'b1;
        end else begin
            if (valid_q && sample_ready) begin
                valid_d = 1'b0;
            end
            if (emit) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ws_prev_q <= 1'b0;
            shift_q   <= '0;
            stage_q   <= '0;
            left_q    <= '0;
            right_q   <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            left_ok_q <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ws_prev_q <= ws_prev_d;
            shift_q   <= shift_d;
            stage_q   <= stage_d;
            left_q    <= left_d;
            right_q   <= right_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            left_ok_q <= left_ok_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign sample_left  = left_q;
    assign sample_right = right_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_error  = ferr_q;

endmodule
